fetch_unit: RTL
===============

# fetch_unit

Program-counter and run-control sequencer for the 8-bit accumulator processor. It owns the PC, drives the instruction-memory address each cycle, and runs a start/halt/done handshake with the test harness. It consumes the accumulator output as the branch target or offset, which closes the accumulator → PC loop. The block sits at the front of the datapath: its `pc_out` addresses instruction ROM, whose immediate bits feed the accumulator's `data_imm_in`.

## Interface
- `PC_W`, default 10: PC width in bits; instruction space is 2^PC_W words.
- `START_ADDR`, default 0: PC value loaded at reset and on every start.
- `CYC_W`, default 16: width of the run-cycle counter.

Ports (one clock; reset is synchronous and active-high):
- `CLK`  in  1: single system clock; all state changes on posedge.
- `RST`  in  1: synchronous, active-high reset.
- `start_req`  in  1: harness start request, level-sensitive.
- `halt_ctrl`  in  1: decoder flag; the current instruction is HALT.
- `branch_ctrl`  in  2: decoder branch type. 00 = none, 01 = absolute, 10 = relative, 11 = reserved (treated as none).
- `branch_cond`  in  1: ALU condition flag; a branch is taken only when 1.
- `acc_in`  in  8: accumulator output, used as branch target or offset.
- `stall`  in  1: hold the PC this cycle (multi-cycle memory op).
- `pc_out`  out  PC_W: registered instruction address.
- `fetch_en`  out  1: instruction at `pc_out` is live this cycle.
- `busy`  out  1: high in RUN.
- `done`  out  1: high in DONE.
- `cycle_count`  out  CYC_W: RUN cycles of the current or last program.

## Operation
The FSM has three states: IDLE, RUN and DONE.

- **IDLE**
  - Holds `pc_out = START_ADDR`.
  - On `start_req = 1`: go to RUN, clear `cycle_count`, load `pc_out = START_ADDR`.
- **RUN**
  - `busy = 1`; `fetch_en = ~stall`.
  - `cycle_count` increments every RUN cycle, including stalled cycles. It saturates at all-ones.
  - Next-PC priority, highest first:
    1. `stall = 1`: PC holds; halt and branch are ignored.
    2. `halt_ctrl = 1`: go to DONE; PC holds at the HALT address.
    3. `branch_ctrl = 01` and `branch_cond = 1`: PC ← zero-extended `acc_in`. Upper PC bits become 0; if `PC_W < 8`, take `acc_in` truncated to `PC_W` bits.
    4. `branch_ctrl = 10` and `branch_cond = 1`: PC ← PC + sign-extended `acc_in`, modulo 2^PC_W.
    5. Otherwise: PC ← PC + 1, modulo 2^PC_W (wraps from all-ones to 0).
  - `start_req` is ignored in RUN.
- **DONE**
  - `done = 1`, `busy = 0`, `fetch_en = 0`.
  - `pc_out` and `cycle_count` hold.
  - Stays in DONE while `start_req = 1`.
  - When `start_req = 0`, goes to IDLE. This forces a fresh rising request for each run.
- **Reserved `branch_ctrl = 11`**: behaves as no branch (PC + 1).

## Timing
- **Reset values** (when `RST = 1` at posedge, from any state, including mid-RUN or while stalled):
  - state = IDLE
  - `pc_out = START_ADDR`, `cycle_count = 0`
  - `busy = 0`, `done = 0`, `fetch_en = 0`
- **Output decoding**
  - `pc_out` and `cycle_count` are registered.
  - `busy` and `done` are decoded from the state register, so they are glitch-free.
  - `fetch_en` is combinational: state == RUN AND `~stall`.
- **Same-cycle decode**: the instruction at `pc_out` is decoded combinationally in the same cycle. `halt_ctrl`, `branch_ctrl`, `branch_cond` and `acc_in` are sampled at the end of that cycle, and the new PC is visible one cycle after the posedge.
- **Start latency**: `start_req` sampled high in IDLE at edge N gives `busy = 1` in cycle N+1, with the first fetch from `START_ADDR` in cycle N+1.
- **HALT**: a HALT executed at cycle N gives `done = 1` from N+1. `cycle_count` includes the HALT cycle.
- **Branch**: a taken branch is a single-cycle redirect with no delay slot.
- **Simultaneous events**:
  - `stall` with halt or branch: stall wins; the halt or branch is re-evaluated next cycle.
  - `halt_ctrl` with a branch: halt wins.

## Test plan
- **Reset mid-run**: start; after 5 cycles assert `RST` for 1 cycle → next cycle `pc_out = 0`, `busy = 0`, `done = 0`, `cycle_count = 0`.
- **Sequential run and halt**: `start_req = 1`, no branches, `halt_ctrl` asserted when `pc_out = 7` →
  - `pc_out` steps 0..7;
  - `done = 1` from the following cycle with `pc_out = 7` and `cycle_count = 8`;
  - after `start_req` drops, one cycle later the FSM is in IDLE with `pc_out = 0`.
- **Branches**:
  - At PC 20, relative with `acc_in = 0xFB` and cond = 1 → next PC 15.
  - At PC 15, absolute with `acc_in = 0xC8` and cond = 1 → next PC 200.
  - Relative with cond = 0 → next PC 16.
- **Wrap-around**:
  - PC 1023 sequential → 0.
  - PC 2, relative `acc_in = 0x80` (−128) → 898.
- **Stall priority**: at PC 9 assert `stall` for 3 cycles while `halt_ctrl = 1` and `branch_ctrl = 01` →
  - PC holds at 9 and `fetch_en = 0` for those cycles;
  - `cycle_count` advances by 3;
  - the halt takes effect on the first unstalled cycle.
- **Saturation** (`CYC_W = 4`): run 20 cycles before HALT → `cycle_count = 15`; `start_req` held high in DONE keeps `done = 1` with no restart.

Source files
------------

// File: rtl/fetch_unit.sv
// Program-counter and run-control sequencer for the 8-bit accumulator processor.
// Owns the PC, runs the IDLE/RUN/DONE start-halt handshake and counts RUN cycles.
module fetch_unit #(
  parameter int          PC_W       = 10,
  parameter int unsigned START_ADDR = 32'd0,
  parameter int          CYC_W      = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start_req,
  input  logic             halt_ctrl,
  input  logic [1:0]       branch_ctrl,
  input  logic             branch_cond,
  input  logic [7:0]       acc_in,
  input  logic             stall,
  output logic [PC_W-1:0]  pc_out,
  output logic             fetch_en,
  output logic             busy,
  output logic             done,
  output logic [CYC_W-1:0] cycle_count
);

  localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [PC_W-1:0]  r_pc;
  logic [PC_W-1:0]  w_pc_nxt;
  logic [PC_W-1:0]  w_pc_inc;
  logic [PC_W-1:0]  w_pc_abs;
  logic [PC_W-1:0]  w_pc_rel;
  logic [CYC_W-1:0] r_cnt;
  logic [CYC_W-1:0] w_cnt_nxt;
  logic [CYC_W-1:0] w_cnt_sat;

  // Absolute target is zero-extended (or truncated); relative offset is sign-extended.
  assign w_pc_inc = r_pc + PC_W'(1'b1);
  assign w_pc_abs = PC_W'(acc_in);
  assign w_pc_rel = r_pc + PC_W'(signed'(acc_in));

  // Saturating RUN-cycle increment.
  always_comb begin
    w_cnt_sat = r_cnt;
    if (r_cnt == {CYC_W{1'b1}}) begin
      w_cnt_sat = r_cnt;
    end else begin
      w_cnt_sat = r_cnt + CYC_W'(1'b1);
    end
  end

  // Next-state, next-PC and counter logic.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        w_pc_nxt = START_PC;
        if (start_req) begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = '0;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        w_cnt_nxt = w_cnt_sat;
        if (stall) begin
          w_pc_nxt = r_pc;
        end else if (halt_ctrl) begin
          w_state_nxt = ST_DONE;
        end else begin
          case (branch_ctrl)
            2'b01:   w_pc_nxt = branch_cond ? w_pc_abs : w_pc_inc;
            2'b10:   w_pc_nxt = branch_cond ? w_pc_rel : w_pc_inc;
            default: w_pc_nxt = w_pc_inc;
          endcase
        end
      end
      ST_DONE: begin
        // Leaving DONE needs start_req low, so each run needs a fresh request.
        if (!start_req) begin
          w_state_nxt = ST_IDLE;
          w_pc_nxt    = START_PC;
        end else begin
          w_state_nxt = ST_DONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_pc_nxt    = START_PC;
      end
    endcase
  end

  // State, PC and cycle-counter registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_pc    <= START_PC;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign pc_out      = r_pc;
  assign cycle_count = r_cnt;
  assign busy        = (r_state == ST_RUN);
  assign done        = (r_state == ST_DONE);
  assign fetch_en    = (r_state == ST_RUN) && !stall;

endmodule
